// File: rtl/lc3_mem_responder_pkg.sv
// Shared types and constants for the LC-3 memory responder.
// The port FSM state type is common to the fetch and data ports.
package lc3_mem_responder_pkg;

   typedef enum logic [1:0] {
      P_IDLE = 2'd0,
      P_WAIT = 2'd1,
      P_DONE = 2'd2
   } port_state_e;

   localparam int          LAT_W_DEF = 4;
   localparam logic [15:0] BASE_ADDR = 16'h3000;

endpackage

// File: rtl/lc3_mem_responder_port_fsm.sv
// One memory port sequencer: accepts a request in IDLE, waits the latched
// number of extra cycles, then signals completion for a single cycle.
module lc3_mem_port_fsm
   import lc3_mem_responder_pkg::*;
#(
   parameter int LAT_W = LAT_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_req,
   input  logic [LAT_W-1:0] i_lat,
   output logic             o_capture,
   output logic             o_done
);

   port_state_e      r_state;
   port_state_e      w_state_nxt;
   logic [LAT_W-1:0] r_cnt;
   logic [LAT_W-1:0] w_cnt_nxt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= P_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Requests are only accepted in IDLE; strobes seen in WAIT/DONE are dropped.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      o_capture   = 1'b0;
      o_done      = 1'b0;
      case (r_state)
         P_IDLE: begin
            if (i_req) begin
               o_capture   = 1'b1;
               w_cnt_nxt   = i_lat;
               w_state_nxt = (i_lat != '0) ? P_WAIT : P_DONE;
            end
         end
         P_WAIT: begin
            w_cnt_nxt = r_cnt - LAT_W'(1);
            if (r_cnt == LAT_W'(1)) begin
               w_state_nxt = P_DONE;
            end
         end
         P_DONE: begin
            o_done      = 1'b1;
            w_state_nxt = P_IDLE;
         end
         default: begin
            w_state_nxt = P_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/lc3_mem_responder.sv
// LC-3 memory responder: independent fetch and data ports with programmable
// wait states over one shared word array, plus a backdoor preload port.
module lc3_mem_responder
   import lc3_mem_responder_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int LAT_W  = LAT_W_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [15:0]      pc,
   input  logic             instrmem_rd,
   output logic [15:0]      Instr_dout,
   output logic             complete_instr,
   input  logic [15:0]      Data_addr,
   input  logic [15:0]      Data_din,
   input  logic             Data_rd,
   input  logic             data_req,
   output logic [15:0]      Data_dout,
   output logic             complete_data,
   input  logic [LAT_W-1:0] fetch_lat,
   input  logic [LAT_W-1:0] data_lat,
   input  logic             ld_en,
   input  logic [15:0]      ld_addr,
   input  logic [15:0]      ld_data
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [15:0]       r_mem [DEPTH];
   logic [ADDR_W-1:0] r_f_addr;
   logic [ADDR_W-1:0] r_d_addr;
   logic [15:0]       r_d_din;
   logic              r_d_rd;
   logic [15:0]       r_instr_hold;
   logic [15:0]       r_data_hold;
   logic              w_f_cap;
   logic              w_f_done;
   logic              w_d_cap;
   logic              w_d_done;
   logic              w_d_wr;
   logic              w_d_rd_done;
   logic [15:0]       w_f_rdata;
   logic [15:0]       w_d_rdata;
   logic              w_unused_addr_hi;

   // Address bits above ADDR_W alias onto the stored array by design.
   assign w_unused_addr_hi = ^{pc[15:ADDR_W], Data_addr[15:ADDR_W], ld_addr[15:ADDR_W]};

   lc3_mem_port_fsm #(.LAT_W(LAT_W)) u_fetch_fsm (
      .i_clk     (clock),
      .i_rst     (reset),
      .i_req     (instrmem_rd),
      .i_lat     (fetch_lat),
      .o_capture (w_f_cap),
      .o_done    (w_f_done)
   );

   lc3_mem_port_fsm #(.LAT_W(LAT_W)) u_data_fsm (
      .i_clk     (clock),
      .i_rst     (reset),
      .i_req     (data_req),
      .i_lat     (data_lat),
      .o_capture (w_d_cap),
      .o_done    (w_d_done)
   );

   always_ff @(posedge clock) begin
      if (w_f_cap) begin
         r_f_addr <= pc[ADDR_W-1:0];
      end
      if (w_d_cap) begin
         r_d_addr <= Data_addr[ADDR_W-1:0];
         r_d_din  <= Data_din;
         r_d_rd   <= Data_rd;
      end
   end

   // Write commits on the edge that ends DONE; a reset on that edge aborts it.
   assign w_d_wr      = w_d_done && !r_d_rd && !reset;
   assign w_d_rd_done = w_d_done && r_d_rd;

   // Preload is issued last so it overrides a same-address port write.
   always_ff @(posedge clock) begin
      if (w_d_wr) begin
         r_mem[r_d_addr] <= r_d_din;
      end
      if (ld_en) begin
         r_mem[ld_addr[ADDR_W-1:0]] <= ld_data;
      end
   end

   assign w_f_rdata = r_mem[r_f_addr];
   assign w_d_rdata = r_mem[r_d_addr];

   always_ff @(posedge clock) begin
      if (reset) begin
         r_instr_hold <= '0;
         r_data_hold  <= '0;
      end else begin
         if (w_f_done) begin
            r_instr_hold <= w_f_rdata;
         end
         if (w_d_rd_done) begin
            r_data_hold <= w_d_rdata;
         end
      end
   end

   assign complete_instr = w_f_done;
   assign complete_data  = w_d_done;
   assign Instr_dout     = w_f_done ? w_f_rdata : r_instr_hold;
   assign Data_dout      = w_d_rd_done ? w_d_rdata : r_data_hold;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Bench for lc3_mem_responder: directed scenarios with literal expectations,
// then randomized traffic compared each cycle against a transaction-level model.
module tb_lc3_mem_responder;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] pc;
   logic        instrmem_rd;
   logic [15:0] Instr_dout;
   logic        complete_instr;
   logic [15:0] Data_addr;
   logic [15:0] Data_din;
   logic        Data_rd;
   logic        data_req;
   logic [15:0] Data_dout;
   logic        complete_data;
   logic [3:0]  fetch_lat;
   logic [3:0]  data_lat;
   logic        ld_en;
   logic [15:0] ld_addr;
   logic [15:0] ld_data;

   lc3_mem_responder #(.ADDR_W(12), .LAT_W(4)) dut (
      .clock          (clock),
      .reset          (reset),
      .pc             (pc),
      .instrmem_rd    (instrmem_rd),
      .Instr_dout     (Instr_dout),
      .complete_instr (complete_instr),
      .Data_addr      (Data_addr),
      .Data_din       (Data_din),
      .Data_rd        (Data_rd),
      .data_req       (data_req),
      .Data_dout      (Data_dout),
      .complete_data  (complete_data),
      .fetch_lat      (fetch_lat),
      .data_lat       (data_lat),
      .ld_en          (ld_en),
      .ld_addr        (ld_addr),
      .ld_data        (ld_data)
   );

   always #5 clock = ~clock;

   int vectors = 0;
   int errors  = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Transaction-level model: each accepted access completes in the cycle
   // accept_edge + 1 + latency; memory is a plain word array.
   logic [15:0] mmem [4096];
   bit          model_valid = 1'b0;
   longint      cyc = 0;
   bit          f_busy = 1'b0;
   bit          d_busy = 1'b0;
   longint      f_due, d_due;
   logic [11:0] f_a, d_a;
   logic [15:0] d_wd;
   bit          d_isrd;
   logic [15:0] hold_i, hold_d;

   always @(posedge clock) begin
      bit fdone, ddone, fbusy0, dbusy0;
      fbusy0 = f_busy;
      dbusy0 = d_busy;
      fdone  = f_busy && (cyc == f_due);
      ddone  = d_busy && (cyc == d_due);
      if (reset) begin
         f_busy = 1'b0;
         d_busy = 1'b0;
         hold_i = 16'h0000;
         hold_d = 16'h0000;
         model_valid = 1'b1;
      end else begin
         if (fdone) begin
            hold_i = mmem[f_a];
            f_busy = 1'b0;
         end
         if (ddone) begin
            if (d_isrd) hold_d = mmem[d_a];
            else        mmem[d_a] = d_wd;
            d_busy = 1'b0;
         end
         if (!fbusy0 && instrmem_rd) begin
            f_busy = 1'b1;
            f_a    = pc[11:0];
            f_due  = cyc + 1 + longint'(fetch_lat);
         end
         if (!dbusy0 && data_req) begin
            d_busy = 1'b1;
            d_a    = Data_addr[11:0];
            d_wd   = Data_din;
            d_isrd = Data_rd;
            d_due  = cyc + 1 + longint'(data_lat);
         end
      end
      if (ld_en) mmem[ld_addr[11:0]] = ld_data;
      cyc++;
   end

   always @(negedge clock) begin
      bit          e_ci, e_cd;
      logic [15:0] e_id, e_dd;
      if (model_valid) begin
         e_ci = f_busy && (cyc == f_due);
         e_cd = d_busy && (cyc == d_due);
         e_id = e_ci ? mmem[f_a] : hold_i;
         e_dd = (e_cd && d_isrd) ? mmem[d_a] : hold_d;
         chk("model_complete_instr", {15'd0, complete_instr}, {15'd0, e_ci});
         chk("model_complete_data", {15'd0, complete_data}, {15'd0, e_cd});
         chk("model_Instr_dout", Instr_dout, e_id);
         chk("model_Data_dout", Data_dout, e_dd);
      end
   end

   task automatic tick();
      @(negedge clock);
   endtask

   initial begin
      reset = 1'b1; instrmem_rd = 1'b0; data_req = 1'b0; pc = '0;
      Data_addr = '0; Data_din = '0; Data_rd = 1'b1; fetch_lat = '0; data_lat = '0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0;

      // Preload the working window while reset is held.
      for (int i = 0; i < 16; i++) begin
         ld_en = 1'b1; ld_addr = 16'h3000 + 16'(i); ld_data = 16'($urandom);
         tick();
      end
      ld_en = 1'b0;
      tick();
      chk("reset_complete_instr", {15'd0, complete_instr}, 16'h0);
      chk("reset_complete_data", {15'd0, complete_data}, 16'h0);
      chk("reset_Instr_dout", Instr_dout, 16'h0000);
      chk("reset_Data_dout", Data_dout, 16'h0000);
      reset = 1'b0;
      tick();

      // Zero-latency fetch.
      ld_en = 1'b1; ld_addr = 16'h3000; ld_data = 16'h1021; tick(); ld_en = 1'b0;
      pc = 16'h3000; fetch_lat = 4'd0; instrmem_rd = 1'b1; tick();
      chk("f0_complete", {15'd0, complete_instr}, 16'h1);
      chk("f0_Instr_dout", Instr_dout, 16'h1021);
      instrmem_rd = 1'b0; tick();
      chk("f0_complete_after", {15'd0, complete_instr}, 16'h0);
      chk("f0_Instr_dout_hold", Instr_dout, 16'h1021);

      // Fetch latency 3; latency input changed while busy.
      pc = 16'h3001; fetch_lat = 4'd3; instrmem_rd = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk($sformatf("f3_complete_c%0d", k), {15'd0, complete_instr}, (k == 4) ? 16'h1 : 16'h0);
         if (k == 1) fetch_lat = 4'd0;
      end
      instrmem_rd = 1'b0; tick();

      // Write then read 16'h4000 with data latency 2.
      Data_addr = 16'h4000; Data_din = 16'hBEEF; Data_rd = 1'b0; data_lat = 4'd2; data_req = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk($sformatf("wr_complete_c%0d", k), {15'd0, complete_data}, (k == 3) ? 16'h1 : 16'h0);
      end
      data_req = 1'b0; tick();
      Data_rd = 1'b1; data_req = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk($sformatf("rd_complete_c%0d", k), {15'd0, complete_data}, (k == 3) ? 16'h1 : 16'h0);
         if (k == 3) chk("rd_Data_dout", Data_dout, 16'hBEEF);
      end
      data_req = 1'b0; tick();

      // Concurrent fetch (lat 1) and data read (lat 5).
      pc = 16'h3002; fetch_lat = 4'd1; instrmem_rd = 1'b1;
      Data_addr = 16'h3003; Data_rd = 1'b1; data_lat = 4'd5; data_req = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk($sformatf("cc_ci_c%0d", k), {15'd0, complete_instr}, (k == 2) ? 16'h1 : 16'h0);
         chk($sformatf("cc_cd_c%0d", k), {15'd0, complete_data}, (k == 6) ? 16'h1 : 16'h0);
         if (k == 2) instrmem_rd = 1'b0;
         if (k == 6) data_req = 1'b0;
      end
      tick();

      // Reset during a pending write aborts it.
      ld_en = 1'b1; ld_addr = 16'h4001; ld_data = 16'h5A5A; tick(); ld_en = 1'b0;
      Data_addr = 16'h4001; Data_din = 16'h1234; Data_rd = 1'b0; data_lat = 4'd4; data_req = 1'b1;
      tick();
      data_req = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_complete_data", {15'd0, complete_data}, 16'h0);
      chk("abort_complete_instr", {15'd0, complete_instr}, 16'h0);
      chk("abort_Instr_dout", Instr_dout, 16'h0000);
      chk("abort_Data_dout", Data_dout, 16'h0000);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("abort_no_complete_%0d", k), {15'd0, complete_data}, 16'h0);
      end
      Data_rd = 1'b1; data_lat = 4'd0; data_req = 1'b1; tick();
      chk("abort_mem_unchanged", Data_dout, 16'h5A5A);
      data_req = 1'b0; tick();

      // Backdoor load beats a data write to the same word on the same edge.
      Data_addr = 16'h4002; Data_din = 16'h1111; Data_rd = 1'b0; data_lat = 4'd0; data_req = 1'b1;
      tick();
      data_req = 1'b0; ld_en = 1'b1; ld_addr = 16'h4002; ld_data = 16'h2222;
      tick();
      ld_en = 1'b0; Data_rd = 1'b1; data_req = 1'b1;
      tick();
      chk("ld_priority", Data_dout, 16'h2222);
      data_req = 1'b0; tick();

      // 16'hFFFF aliases to the top stored word.
      ld_en = 1'b1; ld_addr = 16'h0FFF; ld_data = 16'hC0DE; tick(); ld_en = 1'b0;
      pc = 16'hFFFF; fetch_lat = 4'd0; instrmem_rd = 1'b1; tick();
      chk("alias_top_word", Instr_dout, 16'hC0DE);
      instrmem_rd = 1'b0; tick();

      // Randomized concurrent traffic within an aliased 16-word window.
      for (int c = 0; c < 4000; c++) begin
         logic [3:0] hi, lo;
         hi = 4'($urandom_range(0, 15)); lo = 4'($urandom_range(0, 15));
         pc          = {hi, 8'h00, lo};
         instrmem_rd = ($urandom_range(0, 3) != 0);
         fetch_lat   = 4'($urandom_range(0, 5));
         hi = 4'($urandom_range(0, 15)); lo = 4'($urandom_range(0, 15));
         Data_addr   = {hi, 8'h00, lo};
         Data_din    = 16'($urandom);
         Data_rd     = ($urandom_range(0, 1) != 0);
         data_req    = ($urandom_range(0, 3) != 0);
         data_lat    = 4'($urandom_range(0, 5));
         hi = 4'($urandom_range(0, 15)); lo = 4'($urandom_range(0, 15));
         ld_en       = ($urandom_range(0, 7) == 0);
         ld_addr     = {hi, 8'h00, lo};
         ld_data     = 16'($urandom);
         reset       = ($urandom_range(0, 199) == 0);
         tick();
      end

      reset = 1'b0; instrmem_rd = 1'b0; data_req = 1'b0; ld_en = 1'b0;
      for (int k = 0; k < 20; k++) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/lc3_mem_responder.md
LC3_MEM_RESPONDER -- requirements
Module: lc3_mem_responder

Interface
REQ-001 Parameter ADDR_W, default 12, meaning word-address bits actually stored (2^ADDR_W x 16-bit words; upper address bits ignored).
REQ-002 Parameter LAT_W, default 4, meaning width of the latency configuration inputs.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pc  input  16  instruction fetch address.
REQ-006 instrmem_rd  input  1  fetch request strobe.
REQ-007 Instr_dout  output  16  fetched instruction word.
REQ-008 complete_instr  output  1  fetch-complete strobe, one cycle.
REQ-009 Data_addr  input  16  data access address.
REQ-010 Data_din  input  16  write data.
REQ-011 Data_rd  input  1  1 = read, 0 = write.
REQ-012 data_req  input  1  data access request strobe.
REQ-013 Data_dout  output  16  read data.
REQ-014 complete_data  output  1  data-complete strobe, one cycle.
REQ-015 fetch_lat, data_lat  input  LAT_W  extra wait cycles per fetch / data access.
REQ-016 ld_en, ld_addr[15:0], ld_data[15:0]  input  backdoor preload write port.

Function
REQ-017 Fetch FSM states: F_IDLE, F_WAIT, F_DONE.
REQ-018 In F_IDLE with instrmem_rd=1, capture pc and fetch_lat; go to F_WAIT if latched latency >0, else F_DONE.
REQ-019 F_WAIT decrements a counter each cycle; on reaching 0, go to F_DONE.
REQ-020 In F_DONE, complete_instr=1 and Instr_dout = mem[captured pc] for exactly one cycle; next state F_IDLE.
REQ-021 Fetch latency: request sampled at edge N -> complete_instr high in cycle N+1+fetch_lat.
REQ-022 instrmem_rd while F_WAIT/F_DONE is ignored; requester holds strobe until complete_instr.
REQ-023 Data FSM states D_IDLE, D_WAIT, D_DONE, identical timing to fetch using data_req and data_lat; Data_addr, Data_din, Data_rd captured at request edge.
REQ-024 Write commits to memory at the D_DONE edge; Data_dout holds previous value during a write's D_DONE.
REQ-025 Read returns memory contents at D_DONE, including a write committed in an earlier cycle.
REQ-026 Fetch and data ports operate independently and concurrently.
REQ-027 Fetch of address being written in the same cycle returns old contents (read-before-write).
REQ-028 ld_en write and data-port write to same address same edge: ld_en wins.
REQ-029 Latency change while busy affects only subsequent requests.
REQ-030 Instr_dout, Data_dout hold last value when complete is low.
REQ-031 Address indexing uses addr[ADDR_W-1:0]; 16'hFFFF aliases to top word, no error.

Reset
REQ-032 reset=1 forces both FSMs to IDLE, counters 0, complete_instr=0, complete_data=0, Instr_dout=0, Data_dout=0.
REQ-033 Reset mid-access aborts it; a pending write is not committed; no complete strobe follows.
REQ-034 Memory contents are not cleared by reset; ld_en functions during reset.

Structure
REQ-035 Shared package holds FSM state enum type, LAT_W default and the base address constant 16'h3000.
REQ-036 One sub-module, lc3_mem_port_fsm (IDLE/WAIT/DONE + latency counter), instantiated twice.
REQ-037 Storage is a single 2-write-priority, 2-read array in the top module.

Verification
REQ-038 Preload 16'h3000=16'h1021, fetch_lat=0, pc=16'h3000 strobe at edge N -> Instr_dout=16'h1021, complete_instr high only cycle N+1.
REQ-039 fetch_lat=3 -> complete_instr high exactly cycle N+4, low cycles N+1..N+3.
REQ-040 Write 16'hBEEF to 16'h4000 (data_lat=2), then read 16'h4000 -> Data_dout=16'hBEEF, each completes 3 cycles after request.
REQ-041 Concurrent fetch (lat 1) and data read (lat 5) -> complete_instr at N+2, complete_data at N+6.
REQ-042 Write 16'h1234 to 16'h4001 with data_lat=4, reset at N+2 -> no complete_data, mem[16'h4001] unchanged, outputs 0.
REQ-043 ld_en and data write both target 16'h4002 same edge -> ld_data stored.
